// File: rtl/bram_fifo_ctrl_if.sv
// Stream and BRAM-port bundle for bram_fifo_ctrl.
// The slave modport is the controller; master is the surrounding environment (producer, consumer, BRAM).
interface bram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH+1:0] count;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rd_data,
        output in_ready, out_valid, out_data, count,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_data, count,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO built on a 1R/1W BRAM with a registered read port.
// A 2-entry output buffer hides read latency and gives a single-cycle bypass when the BRAM is empty.
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bram_fifo_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_count_q, ob_count_d;
    word_t                 ob_q [2];
    word_t                 ob_d [2];
    logic [CW-1:0]         count_q, count_d;
    logic                  rst_done_q, rst_done_d;

    logic       rd_issue;
    logic       bypass;
    logic       in_ready;
    logic       push;
    logic       pop;
    logic       mem_write;
    logic [1:0] ob_used;
    logic [1:0] tail;

    // Handshake qualifiers depend on registered state only, so in_ready has no path from in_valid/out_ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ob_used   = ob_count_q + {1'b0, inflight_q};
        rd_issue  = (mem_count_q != '0) && (ob_used < 2'd2);
        bypass    = (mem_count_q == '0) && !inflight_q && (ob_count_q != 2'd2);
        in_ready  = rst_done_q && !rd_issue && (bypass || (mem_count_q < MEM_FULL));
        push      = bus.in_valid && in_ready;
        pop       = (ob_count_q != 2'd0) && bus.out_ready;
        mem_write = push && !bypass;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        inflight_d  = rd_issue;
        rst_done_d  = 1'b1;
        ob_d        = ob_q;
        tail        = ob_count_q - {1'b0, pop};

        if (mem_write) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            mem_count_d = mem_count_q + 1'b1;
        end
        if (rd_issue) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            mem_count_d = mem_count_q - 1'b1;
        end

        // Shift on pop first, then append at the post-pop tail; a read return and a bypass never coincide.
        if (pop) begin
            ob_d[0] = ob_q[1];
        end
        if (inflight_q) begin
            ob_d[tail[0]] = bus.mem_rd_data;
        end else if (push && bypass) begin
            ob_d[tail[0]] = bus.in_data;
        end

        ob_count_d = ob_count_q - {1'b0, pop} + {1'b0, inflight_q} + {1'b0, push && bypass};
        count_d    = CW'(mem_count_d) + CW'(ob_count_d) + CW'(inflight_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
            ob_count_q  <= 2'd0;
            count_q     <= '0;
            rst_done_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= inflight_d;
            ob_count_q  <= ob_count_d;
            count_q     <= count_d;
            rst_done_q  <= rst_done_d;
        end
    end

    // NOTE: buffer storage is not reset; ob_count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        ob_q <= ob_d;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (ob_count_q != 2'd0);
    assign bus.out_data    = ob_q[0];
    assign bus.count       = count_q;
    assign bus.mem_wr_en   = mem_write;
    assign bus.mem_wr_addr = wr_ptr_q;
    assign bus.mem_wr_data = bus.in_data;
    assign bus.mem_rd_addr = rd_ptr_q;

    a_no_wr_on_read: assert property (@(posedge clk) disable iff (!rst_n) !(mem_write && rd_issue));
    a_count_bound:   assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH + 2));
    a_ob_bound:      assert property (@(posedge clk) disable iff (!rst_n) ob_count_q <= 2'd2);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: BRAM model, queue scoreboard and directed/random scenarios.
// The reference is a plain word queue; the FIFO must deliver exactly what was accepted, in order.
module tb_bram_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic chk_en;
    logic t4;

    bram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // BRAM: registered read; a write cycle returns the write data on the read port.
    logic [DW-1:0] mem_model [2**AW];
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem_model[bus.mem_wr_addr] <= bus.mem_wr_data;
            bus.mem_rd_data            <= bus.mem_wr_data;
        end else begin
            bus.mem_rd_data <= mem_model[bus.mem_rd_addr];
        end
    end

    // Reference model: every accepted word enters the queue, every pop must return its head.
    logic [DW-1:0] mq [$];
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
        end else if (chk_en) begin
            if (bus.out_valid && bus.out_ready) begin
                check("pop_nonempty", mq.size() > 0, 1'b1);
                if (mq.size() > 0) check("pop_order", bus.out_data, mq.pop_front());
            end
            if (bus.in_valid && bus.in_ready) mq.push_back(bus.in_data);
        end
    end

    // Per-cycle monitor; a read issue shows up as mem_rd_addr advancing across the following edge.
    logic [AW-1:0] rd_addr_prev;
    logic          wr_prev, ready_prev, rst_prev, t4_prev, have_prev;
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", bus.count, mq.size());
            if (bus.out_valid) begin
                check("valid_nonempty", mq.size() > 0, 1'b1);
                if (mq.size() > 0) check("head", bus.out_data, mq[0]);
            end
            if (have_prev && rst_prev) begin
                if (wr_prev) check("wr_with_rd", bus.mem_rd_addr != rd_addr_prev, 1'b0);
                if (t4_prev) check("t4_ready_vs_rd", ready_prev, bus.mem_rd_addr == rd_addr_prev);
            end
        end
        rd_addr_prev <= bus.mem_rd_addr;
        wr_prev      <= bus.mem_wr_en;
        ready_prev   <= bus.in_ready;
        rst_prev     <= rst_n;
        t4_prev      <= t4;
        have_prev    <= chk_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag, output int pops);
        int cyc;
        pops          = 0;
        cyc           = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((bus.out_valid || bus.count != 0) && cyc < 300) begin
            if (bus.out_valid) pops++;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_valid"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w [3];
        logic [DW-1:0] d;
        logic [DW-1:0] prev;
        int            n;
        int            pops;
        int            pushed;
        int            cyc;

        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        t4      = 1'b0;
        rst_n   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        prev = '0;

        // Reset state
        tick();
        tick();
        check("rst_cycle_ready", bus.in_ready, 1'b0);
        check("rst_count", bus.count, 0);
        check("rst_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        check("rst_ready_after", bus.in_ready, 1'b1);
        check("rst_wr_en", bus.mem_wr_en, 1'b0);

        // T1: A,B bypass into the buffer, C lands at BRAM address 0
        do_reset();
        w[0] = 8'hA1;
        w[1] = 8'hB2;
        w[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            check("t1_ready", bus.in_ready, 1'b1);
            check("t1_wr_en", bus.mem_wr_en, i == 2);
            if (i == 2) begin
                check("t1_wr_addr", bus.mem_wr_addr, 0);
                check("t1_wr_data", bus.mem_wr_data, w[2]);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("t1_count", bus.count, 3);
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_head", bus.out_data, w[0]);

        // T2: fill to capacity, then drain in order
        do_reset();
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready && n < 40) begin
            bus.in_data = DW'($urandom);
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        check("t2_accepted", n, 18);
        check("t2_count", bus.count, 18);
        tick();
        tick();
        check("t2_full_ready", bus.in_ready, 1'b0);
        drain("t2_drain", pops);
        check("t2_pops", pops, 18);

        // T3: empty FIFO streaming through the bypass
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            d = DW'($urandom);
            bus.in_data = d;
            check("t3_ready", bus.in_ready, 1'b1);
            check("t3_no_wr", bus.mem_wr_en, 1'b0);
            if (i > 0) begin
                check("t3_valid", bus.out_valid, 1'b1);
                check("t3_data", bus.out_data, prev);
            end
            prev = d;
            tick();
        end
        drain("t3_drain", pops);

        // T4: streaming with a backlog of 10
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = DW'($urandom);
            check("t4_fill_ready", bus.in_ready, 1'b1);
            tick();
        end
        check("t4_backlog", bus.count, 10);
        bus.out_ready = 1'b1;
        t4 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.in_data = DW'($urandom);
            tick();
        end
        t4 = 1'b0;
        drain("t4_drain", pops);

        // T5: random traffic, 200 pushes
        do_reset();
        pushed = 0;
        cyc    = 0;
        while (pushed < 200 && cyc < 4000) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = DW'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 4);
            if (bus.in_valid && bus.in_ready) pushed++;
            tick();
            cyc++;
        end
        check("t5_pushes", pushed, 200);
        drain("t5_drain", pops);

        // T6: reset with 6 words held and a read in flight
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = DW'($urandom);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        check("t6_count_pre", bus.count, 6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_count", bus.count, 0);
        check("t6_valid", bus.out_valid, 1'b0);
        tick();
        check("t6_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        check("t6_x_valid", bus.out_valid, 1'b1);
        check("t6_x_data", bus.out_data, 8'h5A);
        drain("t6_drain", pops);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
